mmio_responder: RTL

- Responder end of the processor's memory-mapped I/O bus: decodes data-memory loads/stores in the 0xF00000xx/0xF00001xx window and owns the board peripherals.
- Outputs: registered HEX (4 digits, 7-seg encoded), LEDR and LEDG.
- Inputs: synchronized, debounced KEY and SW with sticky ready/overrun status.
- Sits beside data memory; the core muxes memRdData from this block whenever addrHit=1.

---
 rtl/mmio_responder_if.sv | 22 ++
 rtl/mmio_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder_if.sv
// Core-side MMIO bus: address, store/load strobes, store data, read data and hit flag.
// Read data and hit are combinational from the address; stores and load side effects act on the clock edge.
interface mmio_responder_if #(
   parameter int DBITS = 32
);
   logic [DBITS-1:0] memAddr;
   logic             memWrtEn;
   logic [DBITS-1:0] memWrtData;
   logic             memRdEn;
   logic [DBITS-1:0] memRdData;
   logic             addrHit;

   modport master (
      output memAddr, memWrtEn, memWrtData, memRdEn,
      input  memRdData, addrHit
   );

   modport slave (
      input  memAddr, memWrtEn, memWrtData, memRdEn,
      output memRdData, addrHit
   );
endinterface

// File: rtl/mmio_responder.sv
// MMIO peripheral responder: HEX/LEDR/LEDG output registers, debounced KEY/SW with ready/overrun status.
// Stores land on the next edge, reads are combinational; never stalls the core (no backpressure).

module mmio_input_group #(
   parameter int W               = 4,
   parameter bit INVERT          = 1'b0,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_raw,
   input  logic         i_load,
   input  logic         i_ovr_clr,
   output logic [W-1:0] o_data,
   output logic         o_ready,
   output logic         o_overrun
);
   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
   // Sync flops reset to the idle level of the raw pin (keys idle high)
   localparam logic [W-1:0]  SYNC_RST = {W{INVERT}};

   typedef enum logic {ST_IDLE, ST_PENDING} st_t;

   st_t           r_state, w_state_nxt;
   logic          r_ovr, w_ovr_nxt;
   logic [W-1:0]  r_sync1, r_sync2, r_cand, r_data;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  w_sync;
   logic          w_event;

   assign w_sync  = INVERT ? ~r_sync2 : r_sync2;
   assign w_event = (r_cnt == CNT_MAX) && (r_cand != r_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= SYNC_RST;
         r_sync2 <= SYNC_RST;
         r_cand  <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (w_sync != r_cand) begin
            r_cand <= w_sync;
            r_cnt  <= '0;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_event) begin
            r_data <= r_cand;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ovr   <= w_ovr_nxt;
      end
   end

   // A load coinciding with an event consumes the old event; the new one stays pending
   always_comb begin
      w_state_nxt = r_state;
      w_ovr_nxt   = r_ovr;
      case (r_state)
         ST_IDLE: begin
            if (w_event) begin
               w_state_nxt = ST_PENDING;
            end
            if (i_ovr_clr) begin
               w_ovr_nxt = 1'b0;
            end
         end
         ST_PENDING: begin
            if (w_event) begin
               if (!i_load) begin
                  w_ovr_nxt = 1'b1;
               end else if (i_ovr_clr) begin
                  w_ovr_nxt = 1'b0;
               end
            end else begin
               if (i_load) begin
                  w_state_nxt = ST_IDLE;
               end
               if (i_ovr_clr) begin
                  w_ovr_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_data    = r_data;
   assign o_ready   = (r_state == ST_PENDING);
   assign o_overrun = r_ovr;
endmodule

module mmio_responder #(
   parameter int               DBITS           = 32,
   parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
   parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
   parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
   parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
   parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
   parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
   parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
   parameter int               DEBOUNCE_CYCLES = 500000
) (
   input  logic                clk,
   input  logic                reset,
   mmio_responder_if.slave     bus,
   input  logic [3:0]          KEY,
   input  logic [9:0]          SW,
   output logic [6:0]          HEX0,
   output logic [6:0]          HEX1,
   output logic [6:0]          HEX2,
   output logic [6:0]          HEX3,
   output logic [9:0]          LEDR,
   output logic [7:0]          LEDG
);
   logic [15:0]      r_hex;
   logic [9:0]       r_ledr;
   logic [7:0]       r_ledg;

   logic             w_hit_hex, w_hit_ledr, w_hit_ledg, w_hit_key, w_hit_sw, w_hit_kctrl, w_hit_sctrl;
   logic [3:0]       w_key_data;
   logic [9:0]       w_sw_data;
   logic             w_key_rdy, w_key_ovr, w_sw_rdy, w_sw_ovr;
   logic             w_key_load, w_sw_load, w_key_clr, w_sw_clr;
   logic [DBITS-1:0] w_rd_data;
   logic             w_unused;

   assign w_hit_hex   = (bus.memAddr == ADDR_HEX);
   assign w_hit_ledr  = (bus.memAddr == ADDR_LEDR);
   assign w_hit_ledg  = (bus.memAddr == ADDR_LEDG);
   assign w_hit_key   = (bus.memAddr == ADDR_KEY);
   assign w_hit_sw    = (bus.memAddr == ADDR_SW);
   assign w_hit_kctrl = (bus.memAddr == ADDR_KCTRL);
   assign w_hit_sctrl = (bus.memAddr == ADDR_SCTRL);
   assign bus.addrHit = w_hit_hex | w_hit_ledr | w_hit_ledg | w_hit_key |
                        w_hit_sw | w_hit_kctrl | w_hit_sctrl;

   assign w_unused = ^bus.memWrtData[DBITS-1:16];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hex  <= '0;
         r_ledr <= '0;
         r_ledg <= '0;
      end else if (bus.memWrtEn) begin
         if (w_hit_hex)  r_hex  <= bus.memWrtData[15:0];
         if (w_hit_ledr) r_ledr <= bus.memWrtData[9:0];
         if (w_hit_ledg) r_ledg <= bus.memWrtData[7:0];
      end
   end

   // Status writes only ever clear overrun, and only when bit 2 is written as 0
   assign w_key_load = bus.memRdEn & w_hit_key;
   assign w_sw_load  = bus.memRdEn & w_hit_sw;
   assign w_key_clr  = bus.memWrtEn & w_hit_kctrl & ~bus.memWrtData[2];
   assign w_sw_clr   = bus.memWrtEn & w_hit_sctrl & ~bus.memWrtData[2];

   mmio_input_group #(
      .W               (4),
      .INVERT          (1'b1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (KEY),
      .i_load    (w_key_load),
      .i_ovr_clr (w_key_clr),
      .o_data    (w_key_data),
      .o_ready   (w_key_rdy),
      .o_overrun (w_key_ovr)
   );

   mmio_input_group #(
      .W               (10),
      .INVERT          (1'b0),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sw (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (SW),
      .i_load    (w_sw_load),
      .i_ovr_clr (w_sw_clr),
      .o_data    (w_sw_data),
      .o_ready   (w_sw_rdy),
      .o_overrun (w_sw_ovr)
   );

   always_comb begin
      w_rd_data = '0;
      if (w_hit_hex)   w_rd_data = {{(DBITS-16){1'b0}}, r_hex};
      if (w_hit_ledr)  w_rd_data = {{(DBITS-10){1'b0}}, r_ledr};
      if (w_hit_ledg)  w_rd_data = {{(DBITS-8){1'b0}}, r_ledg};
      if (w_hit_key)   w_rd_data = {{(DBITS-4){1'b0}}, w_key_data};
      if (w_hit_sw)    w_rd_data = {{(DBITS-10){1'b0}}, w_sw_data};
      if (w_hit_kctrl) w_rd_data = {{(DBITS-3){1'b0}}, w_key_ovr, 1'b0, w_key_rdy};
      if (w_hit_sctrl) w_rd_data = {{(DBITS-3){1'b0}}, w_sw_ovr, 1'b0, w_sw_rdy};
   end

   assign bus.memRdData = w_rd_data;

   // Active-low segments, bit 6 = g ... bit 0 = a
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign HEX0 = seg7(r_hex[3:0]);
   assign HEX1 = seg7(r_hex[7:4]);
   assign HEX2 = seg7(r_hex[11:8]);
   assign HEX3 = seg7(r_hex[15:12]);
   assign LEDR = r_ledr;
   assign LEDG = r_ledg;
endmodule
